// File: rtl/unary_to_binary_pipe.sv
// Two-stage valid/ready unary/thermometer popcount with bubble detect
// and a saturating running total of delivered counts.
module unary_to_binary_pipe #(
    parameter int UNARY_SIZE   = 16,
    parameter int CHUNK_SIZE   = 4,
    parameter bit THERMO_CHECK = 1'b1,
    parameter int ACC_WIDTH    = 16
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              in_valid_i,
    output logic                              in_ready_o,
    input  logic [UNARY_SIZE-1:0]             unary_i,
    output logic                              out_valid_o,
    input  logic                              out_ready_i,
    output logic [$clog2(UNARY_SIZE+1)-1:0]   binary_o,
    output logic                              bubble_o,
    input  logic                              acc_clr_i,
    output logic [ACC_WIDTH-1:0]              acc_o,
    output logic                              acc_sat_o
);
    localparam int OUT_BITS   = $clog2(UNARY_SIZE + 1);
    localparam int NUM_CHUNKS = (UNARY_SIZE + CHUNK_SIZE - 1) / CHUNK_SIZE;
    localparam int CW         = $clog2(CHUNK_SIZE + 1);
    localparam int PW         = NUM_CHUNKS * CHUNK_SIZE;

    logic [PW-1:0]                 pad;
    logic [PW-1:0]                 mask;
    logic [CHUNK_SIZE-1:0]         chunk;
    logic [CHUNK_SIZE-1:0]         cmask;
    logic [NUM_CHUNKS-1:0][CW-1:0] cnt_d, cnt_q;
    logic [NUM_CHUNKS-1:0]         all_d, all_q;
    logic [NUM_CHUNKS-1:0]         any_d, any_q;
    logic [NUM_CHUNKS-1:0]         thermo_d, thermo_q;
    logic                          s1_valid_d, s1_valid_q;
    logic [OUT_BITS-1:0]           binary_d, binary_q;
    logic                          bubble_d, bubble_q;
    logic                          out_valid_d, out_valid_q;
    logic                          hole;
    logic [ACC_WIDTH-1:0]          acc_d, acc_q, acc_base;
    logic                          sat_d, sat_q;
    logic [ACC_WIDTH:0]            acc_sum;
    logic                          s2_adv;
    logic                          in_accept;
    logic                          out_hs;

    // Padding bits above UNARY_SIZE are zero and masked out of all-ones.
    assign pad  = PW'(unary_i);
    assign mask = PW'({UNARY_SIZE{1'b1}});

    assign s2_adv      = !out_valid_q || out_ready_i;
    assign in_ready_o  = !s1_valid_q || s2_adv;
    assign in_accept   = in_valid_i && in_ready_o;
    assign out_hs      = out_valid_q && out_ready_i;
    assign out_valid_o = out_valid_q;
    assign binary_o    = binary_q;
    assign bubble_o    = bubble_q;
    assign acc_o       = acc_q;
    assign acc_sat_o   = sat_q;

    always_comb begin
        cnt_d      = cnt_q;
        all_d      = all_q;
        any_d      = any_q;
        thermo_d   = thermo_q;
        chunk      = '0;
        cmask      = '0;
        s1_valid_d = in_ready_o ? in_valid_i : s1_valid_q;
        if (in_accept) begin
            for (int k = 0; k < NUM_CHUNKS; k++) begin
                chunk    = pad[k*CHUNK_SIZE +: CHUNK_SIZE];
                cmask    = mask[k*CHUNK_SIZE +: CHUNK_SIZE];
                cnt_d[k] = '0;
                for (int b = 0; b < CHUNK_SIZE; b++) begin
                    cnt_d[k] = cnt_d[k] + CW'(chunk[b]);
                end
                all_d[k]    = &(chunk | ~cmask);
                any_d[k]    = |chunk;
                thermo_d[k] = 1'b1;
                for (int b = 1; b < CHUNK_SIZE; b++) begin
                    if (chunk[b] && !chunk[b-1]) thermo_d[k] = 1'b0;
                end
            end
        end
    end

    // A set bit in any chunk above a chunk that is not full is a bubble.
    always_comb begin
        out_valid_d = out_valid_q;
        binary_d    = binary_q;
        bubble_d    = bubble_q;
        hole        = 1'b0;
        if (s2_adv) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                binary_d = '0;
                for (int k = 0; k < NUM_CHUNKS; k++) begin
                    binary_d = binary_d + OUT_BITS'(cnt_q[k]);
                end
                bubble_d = 1'b0;
                if (THERMO_CHECK) begin
                    for (int k = 0; k < NUM_CHUNKS; k++) begin
                        if (!thermo_q[k] || (hole && any_q[k])) bubble_d = 1'b1;
                        hole = hole | !all_q[k];
                    end
                end
            end
        end
    end

    // Clear applies before the add so a same-cycle handshake still counts.
    always_comb begin
        acc_base = acc_clr_i ? '0 : acc_q;
        acc_d    = acc_base;
        sat_d    = acc_clr_i ? 1'b0 : sat_q;
        acc_sum  = {1'b0, acc_base} + (ACC_WIDTH+1)'(binary_q);
        if (out_hs) begin
            if (acc_sum[ACC_WIDTH]) begin
                acc_d = '1;
                sat_d = 1'b1;
            end else begin
                acc_d = acc_sum[ACC_WIDTH-1:0];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cnt_q       <= '0;
            all_q       <= '0;
            any_q       <= '0;
            thermo_q    <= '0;
            s1_valid_q  <= 1'b0;
            out_valid_q <= 1'b0;
            binary_q    <= '0;
            bubble_q    <= 1'b0;
            acc_q       <= '0;
            sat_q       <= 1'b0;
        end else begin
            cnt_q       <= cnt_d;
            all_q       <= all_d;
            any_q       <= any_d;
            thermo_q    <= thermo_d;
            s1_valid_q  <= s1_valid_d;
            out_valid_q <= out_valid_d;
            binary_q    <= binary_d;
            bubble_q    <= bubble_d;
            acc_q       <= acc_d;
            sat_q       <= sat_d;
        end
    end
endmodule
